// File: rtl/addsub_mp_pkg.sv
// Shared definitions for the multi-precision adder/subtractor: op codes, FSM states
// and default sizing.
package addsub_mp_pkg;

    localparam int WORD_SIZE_DEF = 16;
    localparam int MAX_LIMBS_DEF = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Carry injected into the LS limb: SUB relies on ~y + 1, ADC/SBC take the external carry.
    function automatic logic first_carry(input op_e op, input logic cin);
        case (op)
            OP_ADD:  first_carry = 1'b0;
            OP_SUB:  first_carry = 1'b1;
            default: first_carry = cin;
        endcase
    endfunction

endpackage

// File: rtl/addsub_mp_limb.sv
// One limb of the carry chain: x + (inv ? ~y : y) + c, with the carry into the MSB
// exposed for signed-overflow detection.
module addsub_limb #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         inv,
    input  logic         c,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [W-1:0] y_eff;
    logic [W-1:0] low;
    logic [W:0]   full;

    always_comb begin
        y_eff = inv ? ~y : y;
        low   = {1'b0, x[W-2:0]} + {1'b0, y_eff[W-2:0]} + {{(W-1){1'b0}}, c};
        full  = {1'b0, x} + {1'b0, y_eff} + {{W{1'b0}}, c};
    end

    assign sum   = full[W-1:0];
    assign cout  = full[W];
    assign c_msb = low[W-1];

endmodule

// File: rtl/addsub_mp.sv
// Streaming multi-precision add/subtract: one limb per beat, LS limb first, with a
// single registered output stage and whole-result flags on the MS limb.
module addsub_mp
    import addsub_mp_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int MAX_LIMBS = MAX_LIMBS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [1:0]           op,
    input  logic                 cin,
    input  logic [WORD_SIZE-1:0] x,
    input  logic [WORD_SIZE-1:0] y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_sum,
    output logic                 out_last,
    output logic                 out_cout,
    output logic                 out_ovf,
    output logic                 out_neg,
    output logic                 out_zero,
    output logic                 err,
    input  logic                 err_clr
);

    localparam int CNT_W = $clog2(MAX_LIMBS + 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 carry_q, carry_d;
    op_e                  op_q, op_d;
    logic                 zero_q, zero_d;
    logic                 err_q, err_d;
    logic                 out_valid_q, out_valid_d;
    logic [WORD_SIZE-1:0] out_sum_q, out_sum_d;
    logic                 out_last_q, out_last_d;
    logic                 out_cout_q, out_cout_d;
    logic                 out_ovf_q, out_ovf_d;
    logic                 out_neg_q, out_neg_d;
    logic                 out_zero_q, out_zero_d;

    logic                 accept, is_first, is_last, forced_last, proto_err;
    logic [CNT_W-1:0]     count_eff;
    op_e                  op_cur;
    logic                 c_in;
    logic [WORD_SIZE-1:0] sum;
    logic                 cout, c_msb, zero_cur;

    assign in_ready = !out_valid_q | out_ready;

    // A beat in IDLE always opens a new op; in_first in BUSY abandons the open one.
    always_comb begin
        accept      = in_valid & in_ready;
        is_first    = (state_q == ST_IDLE) | in_first;
        proto_err   = accept & (((state_q == ST_IDLE) & !in_first) |
                                ((state_q == ST_BUSY) & in_first));
        op_cur      = is_first ? op_e'(op) : op_q;
        c_in        = is_first ? first_carry(op_e'(op), cin) : carry_q;
        count_eff   = is_first ? CNT_W'(1) : count_q + CNT_W'(1);
        forced_last = !in_last && (count_eff == CNT_W'(MAX_LIMBS));
        is_last     = in_last | forced_last;
    end

    addsub_limb #(.W(WORD_SIZE)) u_limb (
        .x     (x),
        .y     (y),
        .inv   (op_cur[0]),
        .c     (c_in),
        .sum   (sum),
        .cout  (cout),
        .c_msb (c_msb)
    );

    assign zero_cur = (is_first | zero_q) & (sum == '0);

    // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        carry_d     = carry_q;
        op_d        = op_q;
        zero_d      = zero_q;
        err_d       = (err_q & !err_clr) | proto_err | (accept & forced_last);
        out_valid_d = out_valid_q & !out_ready;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        out_neg_d   = out_neg_q;
        out_zero_d  = out_zero_q;
        if (accept) begin
            state_d     = is_last ? ST_IDLE : ST_BUSY;
            count_d     = is_last ? '0 : count_eff;
            carry_d     = cout;
            op_d        = op_cur;
            zero_d      = zero_cur;
            out_valid_d = 1'b1;
            out_sum_d   = sum;
            out_last_d  = is_last;
            out_cout_d  = cout;
            out_ovf_d   = is_last & (c_msb ^ cout);
            out_neg_d   = is_last & sum[WORD_SIZE-1];
            out_zero_d  = zero_cur;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            carry_q     <= 1'b0;
            op_q        <= OP_ADD;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_neg_q   <= 1'b0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            op_q        <= op_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
            out_neg_q   <= out_neg_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;
    assign out_neg   = out_neg_q;
    assign out_zero  = out_zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_addsub_mp.sv
// Scoreboard bench for addsub_mp: the driver queues expected limbs, a monitor checks
// every output transfer and that stalled outputs hold still.
module tb_addsub_mp;
    import addsub_mp_pkg::*;

    typedef struct packed {
        logic [15:0] sum;
        logic        last;
        logic        cout;
        logic        ovf;
        logic        neg;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, cin = 1'b0;
    logic        out_ready = 1'b1, err_clr = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] x = '0, y = '0;
    logic        in_ready, out_valid, out_last, out_cout, out_ovf, out_neg, out_zero, err;
    logic [15:0] out_sum;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    addsub_mp #(.WORD_SIZE(16), .MAX_LIMBS(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last), .op(op), .cin(cin), .x(x), .y(y),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_last(out_last), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_neg(out_neg), .out_zero(out_zero), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic l, co, ov, ng, z);
        mk = '{sum: s, last: l, cout: co, ovf: ov, neg: ng, zero: z};
    endfunction

    // Presents one beat, waits for acceptance, queues its expected output when asked.
    task automatic send_beat(input logic f, input logic l, input logic [1:0] o, input logic c,
                             input logic [15:0] xv, input logic [15:0] yv,
                             input bit push, input exp_t e);
        int n = 0;
        in_valid = 1'b1; in_first = f; in_last = l; op = o; cin = c; x = xv; y = yv;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end else if (push) begin
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Whole-number reference: each limb's result and carry come from a wide sum of the low limbs.
    task automatic send_op(input logic [1:0] o, input logic c, input logic [127:0] xv,
                           input logic [127:0] yv, input int n);
        logic [128:0] xe, ye, mk_w, p;
        logic         c0;
        int           w;
        exp_t         e;
        c0 = (o == OP_ADD) ? 1'b0 : (o == OP_SUB) ? 1'b1 : c;
        xe = {1'b0, xv};
        ye = o[0] ? ~{1'b0, yv} : {1'b0, yv};
        for (int i = 0; i < n; i++) begin
            w    = 16 * (i + 1);
            mk_w = (129'd1 << w) - 129'd1;
            p    = (xe & mk_w) + (ye & mk_w) + {128'd0, c0};
            e.sum  = p[16*i +: 16];
            e.cout = p[w];
            e.zero = ((p & mk_w) == '0);
            e.last = (i == n - 1);
            e.neg  = e.last & p[w-1];
            e.ovf  = e.last & (xe[w-1] == ye[w-1]) & (p[w-1] != xe[w-1]);
            send_beat(i == 0, i == n - 1, o, c, xv[16*i +: 16], yv[16*i +: 16], 1'b1, e);
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("err_cleared", {31'd0, err}, 32'd0);
    endtask

    initial begin : monitor
        exp_t        e, g;
        logic        stalled = 1'b0;
        logic [15:0] held = '0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (stalled) check("hold_stable", {16'd0, out_sum}, {16'd0, held});
                if (out_ready) begin
                    stalled = 1'b0;
                    g = mk(out_sum, out_last, out_cout, out_ovf, out_neg, out_zero);
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got sum=%h last=%b, required no output",
                                 g.sum, g.last);
                    end else begin
                        e = sb_q.pop_front();
                        if (g !== e) begin
                            errors++;
                            $display("FAIL result_limb: got sum=%h last=%b cout=%b ovf=%b neg=%b zero=%b, required sum=%h last=%b cout=%b ovf=%b neg=%b zero=%b",
                                     g.sum, g.last, g.cout, g.ovf, g.neg, g.zero,
                                     e.sum, e.last, e.cout, e.ovf, e.neg, e.zero);
                        end
                    end
                end else begin
                    stalled = 1'b1;
                    held    = out_sum;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {16'd0, out_sum}, 32'd0);
        check("rst_flags", {27'd0, out_last, out_cout, out_ovf, out_neg, out_zero}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-limb wrap to zero, output one cycle after acceptance.
        send_beat(1, 1, OP_ADD, 0, 16'hFFFF, 16'h0001, 1, mk(16'h0000, 1, 1, 0, 0, 1));
        check("latency_1", {31'd0, out_valid}, 32'd1);

        // Two-limb SUB with a borrow crossing the limb boundary.
        send_beat(1, 0, OP_SUB, 0, 16'h0000, 16'h0001, 1, mk(16'hFFFF, 0, 0, 0, 0, 0));
        send_beat(0, 1, OP_SUB, 0, 16'h0001, 16'h0000, 1, mk(16'h0000, 1, 1, 0, 0, 0));

        // Signed overflow into the sign bit, then SBC with borrow-in.
        send_beat(1, 1, OP_ADD, 0, 16'h7FFF, 16'h0001, 1, mk(16'h8000, 1, 0, 1, 1, 0));
        send_beat(1, 1, OP_SBC, 0, 16'h0000, 16'h0000, 1, mk(16'hFFFF, 1, 0, 0, 1, 0));

        // Four-limb ADC streamed under a three-cycle output stall.
        fork
            send_op(OP_ADC, 1, 128'h0123_4567_89AB_FFFF, 128'h8000_0000_7654_0001, 4);
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                check("in_ready_stall", {31'd0, in_ready}, 32'd0);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        send_op(OP_SUB, 0, 128'h0000_0005_0000, 128'h0000_0005_0000, 3);
        check("err_clean_ops", {31'd0, err}, 32'd0);

        // in_first inside an open op: abandoned limbs still emerge, new op starts with carry 0.
        send_beat(1, 0, OP_ADD, 0, 16'hFFFF, 16'h0001, 1, mk(16'h0000, 0, 1, 0, 0, 1));
        send_beat(0, 0, OP_ADD, 0, 16'h0000, 16'h0000, 1, mk(16'h0001, 0, 0, 0, 0, 0));
        send_beat(1, 1, OP_ADD, 0, 16'h0005, 16'h0003, 1, mk(16'h0008, 1, 0, 0, 0, 0));
        check("err_first_in_busy", {31'd0, err}, 32'd1);
        clear_err();

        // Limb count overrun: the eighth limb is forced last.
        for (int i = 0; i < 8; i++)
            send_beat(i == 0, 0, OP_ADD, 0, 16'h0001, 16'h0001, 1,
                      mk(16'h0002, i == 7, 0, 0, 0, 0));
        check("err_overrun", {31'd0, err}, 32'd1);
        // Ninth beat lands in IDLE without in_first while err_clr is high: err must stay set.
        err_clr = 1'b1;
        send_beat(0, 1, OP_ADD, 0, 16'h0001, 16'h0001, 1, mk(16'h0002, 1, 0, 0, 0, 0));
        err_clr = 1'b0;
        check("err_clr_vs_new", {31'd0, err}, 32'd1);
        clear_err();

        // Asynchronous reset with a partial SUB parked in the output register.
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        send_beat(1, 0, OP_SUB, 0, 16'h0000, 16'h0001, 0, mk(16'h0000, 0, 0, 0, 0, 0));
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_sum", {16'd0, out_sum}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send_beat(0, 1, OP_ADD, 0, 16'h0001, 16'h0002, 1, mk(16'h0003, 1, 0, 0, 0, 0));
        check("err_nonfirst_idle", {31'd0, err}, 32'd1);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
